// File: rtl/ysyx_23060184_scoreboard.sv
// Issue scoreboard: per-register pending-write counters, global in-flight limit and
// a RUN/DRAIN FSM for serializing instructions. Define YSYX_23060184_SB_BYPASS_EN for same-cycle writeback bypass.
module ysyx_23060184_scoreboard #(
    parameter int NREG         = 32,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  id_valid,
    output logic                                  id_ready,
    input  logic [4:0]                            id_rs1,
    input  logic [4:0]                            id_rs2,
    input  logic                                  id_rs1_en,
    input  logic                                  id_rs2_en,
    input  logic [4:0]                            id_rd,
    input  logic                                  id_rd_en,
    input  logic                                  id_serial,
    input  logic                                  wb_valid,
    input  logic [4:0]                            wb_rd,
    input  logic                                  flush,
    output logic [NREG-1:0]                       busy,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
    output logic                                  draining,
    output logic                                  err
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IW-1:0]    INF_MAX = IW'(MAX_INFLIGHT);

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic [IW-1:0]     inflight_q, inflight_d;
    logic              err_q;

    logic [CNT_W-1:0]  cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic              bypass_rs1, bypass_rs2;
    logic              raw_rs1, raw_rs2, waw_stall, cap_stall, serial_stall;
    logic              wr_issue, retire, underflow, fire, inc;

    // Counter lookups for every index the datapath can present.
    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_rs1 = '0;
        cnt_rs2 = '0;
        cnt_rd  = '0;
        cnt_wb  = '0;
        for (int i = 0; i < NREG; i++) begin
            if (id_rs1 == 5'(i)) cnt_rs1 = cnt_q[i];
            if (id_rs2 == 5'(i)) cnt_rs2 = cnt_q[i];
            if (id_rd  == 5'(i)) cnt_rd  = cnt_q[i];
            if (wb_rd  == 5'(i)) cnt_wb  = cnt_q[i];
        end
    end

    assign wr_issue  = id_rd_en && (id_rd != 5'd0);
    assign retire    = wb_valid && (wb_rd != 5'd0) && (cnt_wb != '0);
    assign underflow = wb_valid && (wb_rd != 5'd0) && (cnt_wb == '0);

`ifdef YSYX_23060184_SB_BYPASS_EN
    // The last outstanding write of a source is retiring right now, so its value is forwarded.
    assign bypass_rs1 = (cnt_rs1 == CNT_ONE) && wb_valid && (wb_rd == id_rs1);
    assign bypass_rs2 = (cnt_rs2 == CNT_ONE) && wb_valid && (wb_rd == id_rs2);
    assign cap_stall  = wr_issue && (inflight_q == INF_MAX) && !retire;
`else
    assign bypass_rs1 = 1'b0;
    assign bypass_rs2 = 1'b0;
    assign cap_stall  = wr_issue && (inflight_q == INF_MAX);
`endif

    assign raw_rs1      = id_rs1_en && (id_rs1 != 5'd0) && (cnt_rs1 != '0) && !bypass_rs1;
    assign raw_rs2      = id_rs2_en && (id_rs2 != 5'd0) && (cnt_rs2 != '0) && !bypass_rs2;
    assign waw_stall    = wr_issue && (cnt_rd == CNT_MAX);
    assign serial_stall = id_serial && (inflight_q != '0);

    assign id_ready = rstn && (state_q == ST_RUN) && !flush && !raw_rs1 && !raw_rs2
                      && !waw_stall && !cap_stall && !serial_stall;
    assign fire     = id_valid && id_ready;
    assign inc      = fire && wr_issue;

    // FSM next state: a serializing instruction waits in DRAIN until all writes have retired.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (id_valid && id_serial && (inflight_q != '0)) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_q == '0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        if (flush) state_d = ST_RUN;
    end

    // Simultaneous issue and retire net to zero; the saturation guards keep counts from wrapping.
    always_comb begin
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else if (inc && !retire && (inflight_q != INF_MAX)) begin
            inflight_d = inflight_q + IW'(1);
        end else if (retire && !inc && (inflight_q != '0)) begin
            inflight_d = inflight_q - IW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (inc && (id_rd == 5'(i)) && !(retire && (wb_rd == 5'(i)))) begin
                if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (retire && (wb_rd == 5'(i)) && !(inc && (id_rd == 5'(i)))) begin
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_RUN;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            err_q      <= err_q | (underflow && !flush);
        end
    end

    // NOTE: the counter array is real flop state that gates issue, so it must be reset, unlike a data RAM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NREG; i++) busy[i] = (cnt_q[i] != '0);
    end

    assign inflight = inflight_q;
    assign draining = (state_q == ST_DRAIN);
    assign err      = err_q;

endmodule

// File: doc/ysyx_23060184_scoreboard.md
YSYX_23060184_SCOREBOARD -- requirements
Module: ysyx_23060184_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural integer registers tracked.
REQ-002 SHALL have parameter CNT_W, default 2, width of the per-register pending-write counter (CNT_MAX = 2^CNT_W-1).
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4, maximum total writes issued but not yet written back.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; the clock and reset ports SHALL be named as listed below.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 id_valid  in  1  decoded instruction presented for issue.
REQ-008 id_ready  out  1  scoreboard permits issue; issue fires = id_valid & id_ready.
REQ-009 id_rs1 / id_rs2  in  5 each  source register indices; id_rs1_en / id_rs2_en  in  1 each  source actually read.
REQ-010 id_rd  in  5  destination index; id_rd_en  in  1  instruction writes rd (RegWriteD).
REQ-011 id_serial  in  1  serializing instruction (ecall, mret, CSR write).
REQ-012 wb_valid  in  1  register-file write retiring this cycle (RegWriteW); wb_rd  in  5  its index.
REQ-013 flush  in  1  discard all tracking state.
REQ-014 busy  out  NREG  bit i = counter i nonzero; inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding writes.
REQ-015 draining  out  1  FSM in DRAIN; err  out  1  sticky writeback-underflow flag.

Function
REQ-016 Register x0 SHALL never be pending: issue/writeback to index 0 SHALL not change any counter or inflight.
REQ-017 RAW hazard SHALL exist when rsN_en, rsN != 0 and cnt[rsN] != 0, for either source.
REQ-018 WAW limit: issue SHALL stall when id_rd_en, id_rd != 0 and cnt[id_rd] == CNT_MAX.
REQ-019 Capacity: issue with id_rd_en, id_rd != 0 SHALL stall when inflight == MAX_INFLIGHT.
REQ-020 id_ready SHALL be combinational: state RUN, no flush, no RAW, no WAW limit, no capacity stall; additionally for id_serial, inflight == 0.
REQ-021 FSM states RUN, DRAIN; RUN->DRAIN when id_valid & id_serial & inflight != 0; DRAIN->RUN when inflight == 0 (registered) or flush; id_ready = 0 throughout DRAIN.
REQ-022 On issue fire with id_rd_en, id_rd != 0: cnt[id_rd] +1, inflight +1 at next edge.
REQ-023 On wb_valid, wb_rd != 0, cnt[wb_rd] != 0: cnt[wb_rd] -1, inflight -1 at next edge.
REQ-024 Same-cycle issue and writeback of the same rd SHALL leave cnt[rd] and inflight unchanged; different rds update independently.
REQ-025 wb_valid with wb_rd != 0 and cnt[wb_rd] == 0 SHALL be ignored (no underflow) and set err, which stays 1 until reset.
REQ-026 flush SHALL clear all counters and inflight, force state RUN, force id_ready = 0 that cycle, and override same-cycle issue and writeback; err unaffected.
REQ-027 Counters and inflight SHALL never wrap in either direction.

Reset
REQ-028 While rstn = 0: all counters 0, inflight 0, busy 0, state RUN, draining 0, err 0; id_ready SHALL be 0 while in reset.
REQ-029 Reset asserted mid-DRAIN or with writes outstanding SHALL discard them; writebacks after release to cleared registers SHALL set err per REQ-025.

Configuration
REQ-030 Macro YSYX_23060184_SB_BYPASS_EN SHALL select same-cycle writeback bypass.
REQ-031 Defined: a source whose cnt == 1 with wb_valid & wb_rd == rs that cycle SHALL NOT be a RAW hazard, and a retire that cycle SHALL relieve the capacity stall; id_ready thus depends combinationally on wb_*.
REQ-032 Undefined: hazards and capacity SHALL use registered state only; stall resolves one cycle after writeback.

Verification
REQ-033 Issue rd=5, next cycle issue rs1=5 -> id_ready=0, busy[5]=1 until wb_rd=5; ready same cycle with bypass, next cycle without.
REQ-034 Issue four writes rd=1..4 with no writeback -> inflight=4, fifth rd=6 stalls; rs-only instruction with rd_en=0 issues.
REQ-035 inflight=2, id_valid & id_serial -> draining=1, id_ready=0; after two writebacks inflight=0 -> RUN, serial issues.
REQ-036 Issue rd=7 while wb_rd=7 retires (cnt[7]=1) -> cnt[7] stays 1, inflight unchanged.
REQ-037 wb_valid, wb_rd=9, cnt[9]=0 -> counters unchanged, err=1 sticky; wb_rd=0 -> err unchanged.
REQ-038 flush with inflight=3 in DRAIN plus same-cycle issue -> next cycle inflight=0, busy=0, RUN, issue discarded.
